kernel_window_ctrl: RTL and testbench
=====================================

# kernel_window_ctrl

Sequencing controller for the sliding-window `kernel` shift-register array in the HOG front end. It accepts one pixel column per handshake from the line-buffer stage and issues the shift enable to the kernel. It tracks the image raster position and declares a window valid only when all `BLOCK_WIDTH x BLOCK_HEIGHT` pixels lie inside the image. Valid windows go to the gradient stage with top-left coordinates, and downstream backpressure is honoured.

## Interface
Parameters:
- `BLOCK_WIDTH`, 3, window width in columns (≥2)
- `BLOCK_HEIGHT`, 3, window height in rows (≥2)
- `IMG_WIDTH`, 64, image width in pixels (> `BLOCK_WIDTH`)
- `IMG_HEIGHT`, 128, image height in rows (> `BLOCK_HEIGHT`)
- `X_WIDTH`, `$clog2(IMG_WIDTH)`, column counter/coordinate width
- `Y_WIDTH`, `$clog2(IMG_HEIGHT)`, row counter/coordinate width

Ports:
- `clk`, in, 1, sole clock
- `rst`, in, 1, synchronous active-high reset
- `start`, in, 1, single-cycle pulse that arms one frame
- `col_valid`, in, 1, line buffer presents a full pixel column
- `col_ready`, out, 1, column accepted; fire = `col_valid && col_ready`
- `shift_en`, out, 1, kernel shift strobe; combinational, equals fire
- `win_valid`, out, 1, kernel holds a complete in-image window
- `win_ready`, in, 1, gradient stage consumes the window
- `win_x`, out, `X_WIDTH`, window left column
- `win_y`, out, `Y_WIDTH`, window top row
- `busy`, out, 1, frame in progress
- `frame_done`, out, 1, one-cycle pulse after the last window is consumed

## Operation
- **State machine:** `IDLE`, `ACTIVE`, `DRAIN`, `DONE`.
  - `IDLE`: `col_ready=0`. `start` → `ACTIVE`, clears `x`/`y`.
  - `ACTIVE`: `col_ready = !win_valid || win_ready`.
  - On the fire that accepts column (`IMG_WIDTH-1`, `IMG_HEIGHT-1`) → `DRAIN`.
  - `DRAIN`: `col_ready=0`. Waits until `win_valid==0` or `win_ready`, then → `DONE`.
  - `DONE`: `frame_done=1` for one cycle → `IDLE`.
- **Counters:** `x` counts columns in the current input row and `y` counts input rows (the bottom row of the window).
  - Each fire: `x` increments; at `IMG_WIDTH-1` it wraps to 0 and `y` increments.
  - `y` never wraps within a frame.
- **Window qualification:** on a fire at position (`x`, `y`), `win_valid` is set next cycle iff `x ≥ BLOCK_WIDTH-1` and `y ≥ BLOCK_HEIGHT-1`.
  - `win_x` latches `x-(BLOCK_WIDTH-1)`.
  - `win_y` latches `y-(BLOCK_HEIGHT-1)`.
- **Suppressed windows:** the first `BLOCK_WIDTH-1` columns of every row, and all columns of the first `BLOCK_HEIGHT-1` rows, still shift but produce no window. This discards the wrap-around windows that straddle rows.
- **Clearing `win_valid`:** cleared when `win_ready && !(fire producing a qualified window)`.
  - A simultaneous consume and new qualified fire keeps `win_valid=1` with updated coordinates, giving full throughput of one window per cycle.
- **Stability under backpressure:** while `win_valid && !win_ready`, no shift occurs, and the window contents and coordinates stay stable.
- `start` outside `IDLE` is ignored.
- `busy = (state != IDLE)`.

## Timing
- Fire-to-`win_valid` latency: 1 cycle (registered). `shift_en` is combinational, in the same cycle as the fire.
- Reset values: `state=IDLE`, `x=0`, `y=0`. All outputs are 0: `col_ready`, `shift_en`, `win_valid`, `win_x`, `win_y`, `busy`, `frame_done`.
- Reset mid-frame: the next cycle is `IDLE`, the pending window is dropped, and there is no `frame_done` pulse.
- Windows per frame: `(IMG_WIDTH-BLOCK_WIDTH+1)*(IMG_HEIGHT-BLOCK_HEIGHT+1)`, in raster order.
- With `col_valid` and `win_ready` held high, a frame takes `IMG_WIDTH*IMG_HEIGHT` consecutive fires. `frame_done` follows the last fire by 2 cycles (`DRAIN`, then `DONE`).

## Structure
- Shared package `hog_pkg`:
  - state enum `kwc_state_t`
  - helper function for window-count computation, used by the bench
- One sub-module: `raster_counter` (`x`/`y` with enable, wrap, and last-pixel flag), reusable by the line buffer.
- Controller FSM and window register live in `kernel_window_ctrl`. The kernel datapath is untouched; its `out_ready` is driven from `shift_en`.

## Test plan
All scenarios use `IMG_WIDTH=8`, `IMG_HEIGHT=6`, `BLOCK=3x3`.
- **Full-rate frame:** `start`, `col_valid`/`win_ready` held 1.
  - Exactly 24 windows, raster order (0,0)…(5,3).
  - First `win_valid` the cycle after fire 19 (x=2, y=2).
  - `frame_done` 2 cycles after fire 48.
- **Backpressure:** drop `win_ready` for 5 cycles while window (3,1) is valid.
  - `col_ready=0` and `shift_en=0` throughout.
  - Window and coordinates stable.
  - Resumes with no window lost or duplicated.
- **Row boundary:** fires at x=0,1 of row 3 produce no window.
  - Next window after (5,0) is (0,1).
- **Gaps and ignored inputs:**
  - Random `col_valid` gaps → same 24 windows and coordinates as full rate.
  - `col_valid` in `IDLE` → `col_ready=0`.
  - `start` during `ACTIVE` → ignored.
- **Mid-frame reset:** `rst` at window (2,2).
  - All outputs 0 next cycle, with no `frame_done`.
  - A subsequent `start` gives a clean 24-window frame.

Source files
------------

// File: rtl/hog_pkg.sv
// Shared types and helpers for the HOG front end: controller state encoding
// and the per-frame window count.
package hog_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } kwc_state_t;

  // Number of fully in-image windows produced by one frame.
  function automatic int window_count(input int img_w, input int img_h,
                                      input int blk_w, input int blk_h);
    return (img_w - blk_w + 1) * (img_h - blk_h + 1);
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Column/row raster position counter with synchronous clear, enable, row wrap
// and a flag marking the last pixel of the frame.
module raster_counter
  import hog_pkg::*;
#(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 128,
  parameter int X_WIDTH    = $clog2(IMG_WIDTH),
  parameter int Y_WIDTH    = $clog2(IMG_HEIGHT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               en,
  output logic [X_WIDTH-1:0] x,
  output logic [Y_WIDTH-1:0] y,
  output logic               last
);

  localparam logic [X_WIDTH-1:0] X_LAST = X_WIDTH'(IMG_WIDTH - 1);
  localparam logic [Y_WIDTH-1:0] Y_LAST = Y_WIDTH'(IMG_HEIGHT - 1);

  logic x_wrap;

  assign x_wrap = (x == X_LAST);
  assign last   = x_wrap && (y == Y_LAST);

  // y holds on the final pixel so it never wraps within a frame.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      if (x_wrap) begin
        x <= '0;
        if (!last) begin
          y <= y + Y_WIDTH'(1);
        end
      end else begin
        x <= x + X_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/kernel_window_ctrl.sv
// Sequencing controller for the sliding-window kernel: accepts pixel columns,
// strobes the kernel shift and presents qualified in-image windows downstream.
module kernel_window_ctrl
  import hog_pkg::*;
#(
  parameter int BLOCK_WIDTH  = 3,
  parameter int BLOCK_HEIGHT = 3,
  parameter int IMG_WIDTH    = 64,
  parameter int IMG_HEIGHT   = 128,
  parameter int X_WIDTH      = $clog2(IMG_WIDTH),
  parameter int Y_WIDTH      = $clog2(IMG_HEIGHT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               col_valid,
  output logic               col_ready,
  output logic               shift_en,
  output logic               win_valid,
  input  logic               win_ready,
  output logic [X_WIDTH-1:0] win_x,
  output logic [Y_WIDTH-1:0] win_y,
  output logic               busy,
  output logic               frame_done
);

  localparam logic [X_WIDTH-1:0] X_MIN = X_WIDTH'(BLOCK_WIDTH - 1);
  localparam logic [Y_WIDTH-1:0] Y_MIN = Y_WIDTH'(BLOCK_HEIGHT - 1);

  kwc_state_t state, state_next;

  logic               fire;
  logic               qualified;
  logic               last_pixel;
  logic               clear_pos;
  logic [X_WIDTH-1:0] x;
  logic [Y_WIDTH-1:0] y;

  assign fire      = col_valid && col_ready;
  assign shift_en  = fire;
  assign clear_pos = (state == IDLE) && start;
  assign qualified = (x >= X_MIN) && (y >= Y_MIN);

  raster_counter #(
    .IMG_WIDTH (IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT),
    .X_WIDTH   (X_WIDTH),
    .Y_WIDTH   (Y_WIDTH)
  ) u_raster (
    .clk  (clk),
    .rst  (rst),
    .clear(clear_pos),
    .en   (fire),
    .x    (x),
    .y    (y),
    .last (last_pixel)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = ACTIVE;
      ACTIVE:  if (fire && last_pixel) state_next = DRAIN;
      DRAIN:   if (!win_valid || win_ready) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    col_ready  = 1'b0;
    busy       = (state != IDLE);
    frame_done = (state == DONE);
    if (state == ACTIVE) begin
      col_ready = !win_valid || win_ready;
    end
  end

  // A consume coinciding with a new qualified fire keeps the window valid and
  // just advances the coordinates, giving one window per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_valid <= 1'b0;
      win_x     <= '0;
      win_y     <= '0;
    end else if (fire && qualified) begin
      win_valid <= 1'b1;
      win_x     <= x - X_MIN;
      win_y     <= y - Y_MIN;
    end else if (win_ready) begin
      win_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_kernel_window_ctrl.sv
// Directed self-checking bench for kernel_window_ctrl on an 8x6 image with a
// 3x3 window.
module tb_kernel_window_ctrl;
  import hog_pkg::*;

  localparam int IW = 8;
  localparam int IH = 6;
  localparam int BW = 3;
  localparam int BH = 3;
  localparam int XW = $clog2(IW);
  localparam int YW = $clog2(IH);
  localparam int WIN_COLS = IW - BW + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          col_valid = 1'b0;
  logic          win_ready = 1'b0;
  logic          col_ready;
  logic          shift_en;
  logic          win_valid;
  logic [XW-1:0] win_x;
  logic [YW-1:0] win_y;
  logic          busy;
  logic          frame_done;

  int vectors = 0;
  int miscompares = 0;
  int exp_windows;

  kernel_window_ctrl #(
    .BLOCK_WIDTH (BW),
    .BLOCK_HEIGHT(BH),
    .IMG_WIDTH   (IW),
    .IMG_HEIGHT  (IH),
    .X_WIDTH     (XW),
    .Y_WIDTH     (YW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .col_valid (col_valid),
    .col_ready (col_ready),
    .shift_en  (shift_en),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_x     (win_x),
    .win_y     (win_y),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    logic [10:0] got;
    rst = 1'b1; start = 1'b0; col_valid = 1'b1; win_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    got = {col_ready, shift_en, win_valid, busy, frame_done, win_x, win_y};
    vectors++;
    if (got !== 11'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got %b expected %b", got, 11'd0);
    end
    rst = 1'b0; col_valid = 1'b0;
  endtask

  task automatic test_idle_inputs();
    logic [2:0] got;
    col_valid = 1'b1; win_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      got = {col_ready, shift_en, busy};
      vectors++;
      if (got !== 3'b000) begin
        miscompares++;
        $display("[TB] FAIL idle_col_valid cyc %0d: got %b expected 000", i, got);
      end
    end
    col_valid = 1'b0;
  endtask

  // Runs one frame against a cycle model of the handshake and a raster-order
  // window scoreboard; optional gaps, backpressure at (3,1), and a stray start.
  task automatic run_frame(input string tag, input bit gaps, input bit bp, input bit poke_start);
    int cyc, fire_cnt, win_idx, fire19_cyc, first_win_cyc, last_fire_cyc, done_cyc;
    int bp_left, bp_seen, m_x, m_y, m_wx, m_wy, phase, exp_wx, exp_wy;
    bit m_wv, exp_ready, fire, qual, bp_done;
    logic [4:0] exp_flags, got_flags;
    fire_cnt = 0; win_idx = 0; fire19_cyc = -1; first_win_cyc = -1;
    last_fire_cyc = -1; done_cyc = -1; bp_left = 0; bp_seen = 0; bp_done = 0;
    m_x = 0; m_y = 0; m_wx = 0; m_wy = 0; m_wv = 0; phase = 0;

    @(posedge clk); #1;
    start = 1'b1; col_valid = 1'b0; win_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;

    for (cyc = 0; cyc < 2000 && phase != 3; cyc++) begin
      if (bp && !bp_done && m_wv && m_wx == 3 && m_wy == 1) begin
        bp_left = 5; bp_done = 1;
      end
      col_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      win_ready = (bp_left == 0);
      start = poke_start && (cyc == 10);
      #1;
      exp_ready = (phase == 0) && (!m_wv || win_ready);
      fire = col_valid && exp_ready;
      exp_flags = {exp_ready, fire, m_wv, phase != 3, phase == 2};
      got_flags = {col_ready, shift_en, win_valid, busy, frame_done};
      vectors++;
      if (got_flags !== exp_flags) begin
        miscompares++;
        $display("[TB] FAIL %s flags cyc %0d: got %b expected %b (ready,shift,wv,busy,done)",
                 tag, cyc, got_flags, exp_flags);
      end
      if (m_wv) begin
        vectors++;
        if (win_x !== XW'(m_wx) || win_y !== YW'(m_wy)) begin
          miscompares++;
          $display("[TB] FAIL %s coords cyc %0d: got (%0d,%0d) expected (%0d,%0d)",
                   tag, cyc, win_x, win_y, m_wx, m_wy);
        end
      end
      if (win_valid === 1'b1 && first_win_cyc < 0) first_win_cyc = cyc;
      if (frame_done === 1'b1 && done_cyc < 0) done_cyc = cyc;
      if (win_valid === 1'b1 && win_ready) begin
        exp_wx = win_idx % WIN_COLS;
        exp_wy = win_idx / WIN_COLS;
        vectors++;
        if (win_x !== XW'(exp_wx) || win_y !== YW'(exp_wy)) begin
          miscompares++;
          $display("[TB] FAIL %s order #%0d: got (%0d,%0d) expected (%0d,%0d)",
                   tag, win_idx, win_x, win_y, exp_wx, exp_wy);
        end
        win_idx++;
      end
      if (bp_left > 0) begin
        bp_left--; bp_seen++;
      end

      case (phase)
        1: if (!m_wv || win_ready) phase = 2;
        2: phase = 3;
        default: ;
      endcase
      qual = fire && (m_x >= BW - 1) && (m_y >= BH - 1);
      if (qual) begin
        m_wv = 1; m_wx = m_x - (BW - 1); m_wy = m_y - (BH - 1);
      end else if (win_ready) begin
        m_wv = 0;
      end
      if (fire) begin
        fire_cnt++;
        if (fire_cnt == 19) fire19_cyc = cyc;
        if (m_x == IW - 1 && m_y == IH - 1) begin
          phase = 1; last_fire_cyc = cyc;
        end
        if (m_x == IW - 1) begin
          m_x = 0; m_y++;
        end else begin
          m_x++;
        end
      end
      @(posedge clk); #1;
    end
    start = 1'b0; col_valid = 1'b0;

    vectors++;
    if (phase != 3) begin
      miscompares++;
      $display("[TB] FAIL %s timeout: frame reached phase %0d, required 3", tag, phase);
    end
    vectors++;
    if (win_idx != exp_windows) begin
      miscompares++;
      $display("[TB] FAIL %s window_count: got %0d expected %0d", tag, win_idx, exp_windows);
    end
    vectors++;
    if (fire_cnt != IW * IH) begin
      miscompares++;
      $display("[TB] FAIL %s fire_count: got %0d expected %0d", tag, fire_cnt, IW * IH);
    end
    vectors++;
    if (fire19_cyc < 0 || first_win_cyc != fire19_cyc + 1) begin
      miscompares++;
      $display("[TB] FAIL %s first_window: got cyc %0d expected %0d", tag, first_win_cyc, fire19_cyc + 1);
    end
    vectors++;
    if (last_fire_cyc < 0 || done_cyc != last_fire_cyc + 2) begin
      miscompares++;
      $display("[TB] FAIL %s frame_done: got cyc %0d expected %0d", tag, done_cyc, last_fire_cyc + 2);
    end
    if (bp) begin
      vectors++;
      if (bp_seen != 5) begin
        miscompares++;
        $display("[TB] FAIL %s stall_cycles: got %0d expected 5", tag, bp_seen);
      end
    end
  endtask

  task automatic test_full_rate();
    run_frame("full_rate", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_frame("backpressure", 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_gaps_and_start();
    run_frame("gaps_start", 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_row_boundary();
    logic [6:0] got;
    logic [6:0] expv [4];
    expv[0] = {1'b1, 3'd5, 3'd0};
    expv[1] = {1'b0, 3'd5, 3'd0};
    expv[2] = {1'b0, 3'd5, 3'd0};
    expv[3] = {1'b1, 3'd0, 3'd1};
    @(posedge clk); #1;
    start = 1'b1; win_ready = 1'b1; col_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; col_valid = 1'b1;
    repeat (23) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      got = {win_valid, win_x, win_y};
      vectors++;
      if (got !== expv[i]) begin
        miscompares++;
        $display("[TB] FAIL row_boundary step %0d: got v=%b (%0d,%0d) expected v=%b (%0d,%0d)",
                 i, got[6], got[5:3], got[2:0], expv[i][6], expv[i][5:3], expv[i][2:0]);
      end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; col_valid = 1'b0;
  endtask

  task automatic test_mid_frame_reset();
    logic [6:0]  got_win;
    logic [10:0] got;
    @(posedge clk); #1;
    start = 1'b1; win_ready = 1'b1; col_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; col_valid = 1'b1;
    repeat (37) @(posedge clk);
    #1;
    got_win = {win_valid, win_x, win_y};
    vectors++;
    if (got_win !== {1'b1, 3'd2, 3'd2}) begin
      miscompares++;
      $display("[TB] FAIL pre_reset_window: got v=%b (%0d,%0d) expected v=1 (2,2)",
               got_win[6], got_win[5:3], got_win[2:0]);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    got = {col_ready, shift_en, win_valid, busy, frame_done, win_x, win_y};
    vectors++;
    if (got !== 11'd0) begin
      miscompares++;
      $display("[TB] FAIL mid_reset_outputs: got %b expected %b", got, 11'd0);
    end
    col_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      vectors++;
      if ({busy, frame_done} !== 2'b00) begin
        miscompares++;
        $display("[TB] FAIL mid_reset_quiet cyc %0d: got busy,done=%b%b expected 00", i, busy, frame_done);
      end
    end
    run_frame("after_reset", 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    exp_windows = window_count(IW, IH, BW, BH);
    $display("[TB] kernel_window_ctrl bench, %0d windows per frame", exp_windows);
    test_reset();
    test_idle_inputs();
    test_full_rate();
    test_backpressure();
    test_row_boundary();
    test_gaps_and_start();
    test_mid_frame_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
